// File: rtl/i2s_pkg.sv
// Shared constants and the receiver state encoding for the I2S receive path.
package i2s_pkg;

    localparam int AUDIO_DW_DEFAULT = 8;
    localparam int CNT_W_DEFAULT    = 6;

    // Word-select polarity: low carries the left channel, high the right.
    localparam logic WS_LEFT  = 1'b0;
    localparam logic WS_RIGHT = 1'b1;

    typedef enum logic {
        SEARCH = 1'b0,
        RUN    = 1'b1
    } rx_state_e;

endpackage

// File: rtl/i2s_pin_sync.sv
// Brings the asynchronous I2S pins into the clk_i domain and detects sck rising edges.
// ws and sd are delivered from the same synchronizer depth as the sck stage that
// produces the rise strobe, so they are sampled consistently with that edge.
module i2s_pin_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sck_i,
    input  logic ws_i,
    input  logic sd_i,
    output logic rise_o,
    output logic ws_o,
    output logic sd_o
);

    // Bit 0 is the first synchronizer flop, bit 1 the second, bit 2 the edge-detect history.
    logic [2:0] sck_sync;
    logic [1:0] ws_sync;
    logic [1:0] sd_sync;

    // Shift each pin through its synchronizer chain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sck_sync <= '0;
            ws_sync  <= '0;
            sd_sync  <= '0;
        end else begin
            sck_sync <= {sck_sync[1:0], sck_i};
            ws_sync  <= {ws_sync[0], ws_i};
            sd_sync  <= {sd_sync[0], sd_i};
        end
    end

    assign rise_o = sck_sync[1] & ~sck_sync[2];
    assign ws_o   = ws_sync[1];
    assign sd_o   = sd_sync[1];

endmodule

// File: rtl/i2s_rx.sv
// Philips-format I2S slave receiver. Locks on a word-select transition, assembles
// MSB-first words and publishes each completed slot to its channel with a one-cycle
// valid strobe. Slots longer than AUDIO_DW are truncated, shorter ones are left-aligned.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int AUDIO_DW = AUDIO_DW_DEFAULT,
    parameter int CNT_W    = CNT_W_DEFAULT
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic                sck_i,
    input  logic                ws_i,
    input  logic                sd_i,
    output logic [AUDIO_DW-1:0] l_data_o,
    output logic [AUDIO_DW-1:0] r_data_o,
    output logic                l_valid_o,
    output logic                r_valid_o,
    output logic                short_slot_o,
    output logic                locked_o,
    output rx_state_e           state_o
);

    localparam logic [CNT_W:0] DW_CMP = (CNT_W + 1)'(AUDIO_DW);

    logic rise;
    logic ws_s;
    logic sd_s;

    rx_state_e           state_q;
    rx_state_e           state_d;
    logic                ws_prev_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_inc;
    logic [AUDIO_DW-1:0] shreg_q;
    logic [AUDIO_DW-1:0] word_next;
    logic [AUDIO_DW-1:0] l_data_q;
    logic [AUDIO_DW-1:0] r_data_q;
    logic                l_valid_q;
    logic                r_valid_q;
    logic                short_q;
    logic                ws_change;
    logic                publish;
    logic                short_d;

    i2s_pin_sync u_pin_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .sck_i  (sck_i),
        .ws_i   (ws_i),
        .sd_i   (sd_i),
        .rise_o (rise),
        .ws_o   (ws_s),
        .sd_o   (sd_s)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SEARCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, publish decision and the word as it would look with this edge's bit written.
    always_comb begin
        state_d   = state_q;
        publish   = 1'b0;
        ws_change = rise && (ws_s != ws_prev_q);
        word_next = shreg_q;
        cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        short_d   = ({1'b0, cnt_q} + (CNT_W + 1)'(1)) < DW_CMP;
        // Bit positions past the stored width never match, which gives truncation.
        for (int i = 0; i < AUDIO_DW; i++) begin
            if ({1'b0, cnt_q} == (CNT_W + 1)'(AUDIO_DW - 1 - i)) begin
                word_next[i] = sd_s;
            end
        end
        if (!en_i) begin
            // Disable wins over a publishing edge in the same cycle.
            state_d = SEARCH;
        end else begin
            case (state_q)
                SEARCH: if (ws_change) state_d = RUN;
                RUN:    if (ws_change) publish = 1'b1;
                default: state_d = SEARCH;
            endcase
        end
    end

    // Datapath: ws history, bit counter, shift register and the published outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ws_prev_q <= 1'b0;
            cnt_q     <= '0;
            shreg_q   <= '0;
            l_data_q  <= '0;
            r_data_q  <= '0;
            l_valid_q <= 1'b0;
            r_valid_q <= 1'b0;
            short_q   <= 1'b0;
        end else begin
            l_valid_q <= 1'b0;
            r_valid_q <= 1'b0;
            short_q   <= 1'b0;
            // ws history follows every edge, also while disabled, so a later enable
            // mid-slot does not mistake the current channel for a transition.
            if (rise) begin
                ws_prev_q <= ws_s;
            end
            if (!en_i) begin
                cnt_q   <= '0;
                shreg_q <= '0;
            end else if (rise) begin
                if (state_q == SEARCH) begin
                    // The bit at the locking edge belongs to a partial slot and is dropped.
                    cnt_q   <= '0;
                    shreg_q <= '0;
                end else if (publish) begin
                    if (ws_prev_q == WS_LEFT) begin
                        l_data_q  <= word_next;
                        l_valid_q <= 1'b1;
                    end else begin
                        r_data_q  <= word_next;
                        r_valid_q <= 1'b1;
                    end
                    short_q <= short_d;
                    cnt_q   <= '0;
                    shreg_q <= '0;
                end else begin
                    shreg_q <= word_next;
                    cnt_q   <= cnt_inc;
                end
            end
        end
    end

    assign l_data_o     = l_data_q;
    assign r_data_o     = r_data_q;
    assign l_valid_o    = l_valid_q;
    assign r_valid_o    = r_valid_q;
    assign short_slot_o = short_q;
    assign locked_o     = (state_q == RUN);
    assign state_o      = state_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: drives an I2S master stream at clk/8 and checks the
// published words, strobes, lock behaviour and timing against hand-computed values.
module tb_i2s_rx;
    import i2s_pkg::*;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          sck = 1'b0;
    logic          ws = 1'b0;
    logic          sd = 1'b0;
    logic [DW-1:0] l_data;
    logic [DW-1:0] r_data;
    logic          l_valid;
    logic          r_valid;
    logic          short_slot;
    logic          locked;
    rx_state_e     state;

    int checks = 0;
    int errors = 0;

    // Clock and cycle counter.
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    i2s_rx #(.AUDIO_DW(DW), .CNT_W(6)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .en_i         (en),
        .sck_i        (sck),
        .ws_i         (ws),
        .sd_i         (sd),
        .l_data_o     (l_data),
        .r_data_o     (r_data),
        .l_valid_o    (l_valid),
        .r_valid_o    (r_valid),
        .short_slot_o (short_slot),
        .locked_o     (locked),
        .state_o      (state)
    );

    // Scoreboard: each published word is {channel, short flag, data}.
    logic [DW+1:0] got_q[$];
    logic [DW+1:0] exp_q[$];
    int            lat_q[$];
    int            last_rise_cyc = 0;
    int            dual_cnt = 0;
    int            orphan_short_cnt = 0;
    logic          ws_drv_prev = 1'b0;

    // Monitor, sampling on the falling clock edge.
    always @(negedge clk) begin
        if (l_valid && r_valid) dual_cnt++;
        if (short_slot && !l_valid && !r_valid) orphan_short_cnt++;
        if (l_valid) begin
            got_q.push_back({WS_LEFT, short_slot, l_data});
            lat_q.push_back(cyc - last_rise_cyc);
        end
        if (r_valid) begin
            got_q.push_back({WS_RIGHT, short_slot, r_data});
            lat_q.push_back(cyc - last_rise_cyc);
        end
    end

    // Safety net against a hung run.
    initial begin
        #500000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    // One sck period: 4 clk low, 4 clk high; pins change while sck is low.
    task automatic send_bit(input logic w, input logic d);
        @(negedge clk);
        sck = 1'b0;
        ws  = w;
        sd  = d;
        repeat (4) @(negedge clk);
        sck = 1'b1;
        if (w != ws_drv_prev) last_rise_cyc = cyc;
        ws_drv_prev = w;
        repeat (3) @(negedge clk);
    endtask

    // Philips slot: ws already shows the next channel during the LSB.
    task automatic send_slot(input logic ch, input logic [15:0] word, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            send_bit((i == 0) ? ~ch : ch, word[i]);
        end
    endtask

    // Let the monitor record any strobe from the last edge.
    task automatic settle();
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        int bad = 0;
        logic [7:0] pre = 8'h11;
        rst_n = 1'b0;
        en    = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            sck = ~sck;
            ws  = i[2];
            sd  = i[0];
            if ({l_data, r_data, l_valid, r_valid, short_slot, locked} !== '0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL reset_outputs nonzero_cycles=%0d req=0", bad); end
        checks++;
        if (state !== SEARCH) begin errors++; $display("FAIL reset_state got=%0d req=%0d", state, SEARCH); end
        sck = 1'b1; ws = 1'b0; sd = 1'b0; ws_drv_prev = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        got_q.delete();
        for (int i = 7; i >= 1; i--) send_bit(1'b0, pre[i]);
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL reset_lock_early got=%b req=0", locked); end
        send_bit(1'b1, pre[0]);
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL reset_lock_after_ws got=%b req=1", locked); end
        send_slot(WS_RIGHT, 16'h0022, 8);
        settle();
        exp_q = '{{WS_RIGHT, 1'b0, 8'h22}};
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL reset_first_count got=%0d req=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL reset_first_word[%0d] got=%h req=%h", i, got_q[i], exp_q[i]); end
        end
        checks++;
        if (l_data !== 8'h00) begin errors++; $display("FAIL reset_unpublished_left got=%h req=00", l_data); end
    endtask

    task automatic test_8bit();
        got_q.delete(); lat_q.delete(); exp_q.delete();
        for (int f = 0; f < 3; f++) begin
            send_slot(WS_LEFT, 16'h00A5, 8);
            send_slot(WS_RIGHT, 16'h003C, 8);
            exp_q.push_back({WS_LEFT, 1'b0, 8'hA5});
            exp_q.push_back({WS_RIGHT, 1'b0, 8'h3C});
        end
        settle();
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL w8_count got=%0d req=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL w8_word[%0d] got=%h req=%h", i, got_q[i], exp_q[i]); end
            // Pin edge in cycle 1, rise strobe in cycle 3, strobe in cycle 4: three edges later.
            checks++;
            if (lat_q[i] != 3) begin errors++; $display("FAIL w8_latency[%0d] got=%0d req=3", i, lat_q[i]); end
        end
    endtask

    task automatic test_16bit();
        got_q.delete(); exp_q.delete();
        for (int f = 0; f < 2; f++) begin
            send_slot(WS_LEFT, 16'hA5F0, 16);
            send_slot(WS_RIGHT, 16'h0F3C, 16);
            exp_q.push_back({WS_LEFT, 1'b0, 8'hA5});
            exp_q.push_back({WS_RIGHT, 1'b0, 8'h0F});
        end
        settle();
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL w16_count got=%0d req=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL w16_word[%0d] got=%h req=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_6bit();
        got_q.delete(); exp_q.delete();
        for (int f = 0; f < 2; f++) begin
            send_slot(WS_LEFT, 16'b101101, 6);
            send_slot(WS_RIGHT, 16'b010011, 6);
            exp_q.push_back({WS_LEFT, 1'b1, 8'hB4});
            exp_q.push_back({WS_RIGHT, 1'b1, 8'h4C});
        end
        settle();
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL w6_count got=%0d req=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL w6_word[%0d] got=%h req=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_mid_slot();
        logic [7:0] part = 8'h99;
        got_q.delete();
        en = 1'b0;
        send_slot(WS_LEFT, 16'h0055, 8);
        for (int i = 7; i >= 5; i--) send_bit(1'b1, part[i]);
        checks++;
        if (got_q.size() != 0 || locked !== 1'b0) begin
            errors++; $display("FAIL mid_disabled events=%0d locked=%b req=0/0", got_q.size(), locked);
        end
        en = 1'b1;
        for (int i = 4; i >= 1; i--) send_bit(1'b1, part[i]);
        send_bit(1'b0, part[0]);
        send_slot(WS_LEFT, 16'h0096, 8);
        send_slot(WS_RIGHT, 16'h0069, 8);
        settle();
        exp_q = '{{WS_LEFT, 1'b0, 8'h96}, {WS_RIGHT, 1'b0, 8'h69}};
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL mid_count got=%0d req=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL mid_word[%0d] got=%h req=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_enable_drop();
        logic [7:0] part = 8'hC3;
        got_q.delete();
        for (int i = 7; i >= 5; i--) send_bit(1'b0, part[i]);
        en = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL en_locked_drop got=%b req=0", locked); end
        checks++;
        if (l_data !== 8'h96) begin errors++; $display("FAIL en_hold_left got=%h req=96", l_data); end
        en = 1'b1;
        for (int i = 4; i >= 1; i--) send_bit(1'b0, part[i]);
        send_bit(1'b1, part[0]);
        send_slot(WS_RIGHT, 16'h005A, 8);
        send_slot(WS_LEFT, 16'h00E7, 8);
        settle();
        exp_q = '{{WS_RIGHT, 1'b0, 8'h5A}, {WS_LEFT, 1'b0, 8'hE7}};
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL en_count got=%0d req=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL en_word[%0d] got=%h req=%h", i, got_q[i], exp_q[i]); end
        end
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL en_relock got=%b req=1", locked); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] part = 8'h3C;
        got_q.delete();
        send_slot(WS_RIGHT, 16'h0081, 8);
        settle();
        checks++;
        if (got_q.size() != 1 || r_data !== 8'h81) begin
            errors++; $display("FAIL rstmid_pre events=%0d r_data=%h req=1/81", got_q.size(), r_data);
        end
        got_q.delete();
        for (int i = 7; i >= 5; i--) send_bit(1'b0, part[i]);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({l_data, r_data, l_valid, r_valid, short_slot, locked} !== '0) begin
            errors++;
            $display("FAIL rstmid_clear l=%h r=%h lv=%b rv=%b sh=%b lk=%b req=all0", l_data, r_data, l_valid, r_valid, short_slot, locked);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 4; i >= 1; i--) send_bit(1'b0, part[i]);
        send_bit(1'b1, part[0]);
        send_slot(WS_RIGHT, 16'h0024, 8);
        settle();
        checks++;
        if (l_data !== 8'h00) begin errors++; $display("FAIL rstmid_left_zero got=%h req=00", l_data); end
        send_slot(WS_LEFT, 16'h0042, 8);
        settle();
        exp_q = '{{WS_RIGHT, 1'b0, 8'h24}, {WS_LEFT, 1'b0, 8'h42}};
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rstmid_count got=%0d req=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_word[%0d] got=%h req=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_8bit();
        test_16bit();
        test_6bit();
        test_mid_slot();
        test_enable_drop();
        test_reset_mid();
        checks++;
        if (dual_cnt != 0) begin errors++; $display("FAIL dual_valid cycles=%0d req=0", dual_cnt); end
        checks++;
        if (orphan_short_cnt != 0) begin errors++; $display("FAIL short_without_valid cycles=%0d req=0", orphan_short_cnt); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
